// File: rtl/peripheral_bus_pkg.sv
// Shared types and helpers for the byte-wide peripheral bus slave.
package peripheral_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR
  } state_e;

  // Transfer length in bytes for an encoded size (0..3 -> 1,2,4,8).
  function automatic logic [3:0] size_to_len(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/peripheral_bus_slave_mem.sv
// Single-port byte RAM backing the bus slave: synchronous write, combinational read.
module peripheral_bus_slave_mem #(
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/peripheral_bus_slave.sv
// Memory-mapped byte slave: decodes a bus transfer, inserts wait states per beat,
// streams bytes to/from the backing RAM and flags illegal requests with an error pulse.
module peripheral_bus_slave
  import peripheral_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  sig_clock,
  input  logic                  sig_reset,
  input  logic [ADDR_WIDTH-1:0] sig_addr,
  input  logic [1:0]            sig_size,
  input  logic                  sig_read,
  input  logic                  sig_write,
  input  logic                  sig_start,
  input  logic                  sig_bip,
  input  logic [DATA_WIDTH-1:0] sig_data_in,
  output logic [DATA_WIDTH-1:0] sig_data_out,
  output logic                  sig_data_oe,
  output logic                  sig_wait,
  output logic                  sig_error
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int AXW    = ADDR_WIDTH + 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [2:0]            beat_q, beat_d;
  logic [3:0]            wait_q, wait_d;

  logic [AXW-1:0]        end_addr;
  logic                  range_bad;
  logic                  last_beat;
  logic                  beat_fire;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // End address is computed one bit wider so a request near the top of the
  // address space cannot wrap around and pass the range check.
  assign end_addr  = {1'b0, sig_addr} + AXW'(size_to_len(sig_size)) - AXW'(1);
  assign range_bad = end_addr >= AXW'(MEM_DEPTH);
  assign last_beat = 4'(beat_q) == (size_to_len(size_q) - 4'd1);

  // A DATA cycle only counts when the master still holds bip; otherwise it is an abort.
  assign beat_fire    = (state_q == ST_DATA) && sig_bip;
  assign mem_we       = beat_fire && write_q && sig_reset;
  assign sig_data_oe  = beat_fire && !write_q;
  assign sig_data_out = sig_data_oe ? mem_rdata : '0;
  assign sig_wait     = (state_q == ST_WAIT);
  assign sig_error    = (state_q == ST_ERR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (sig_start) begin
          addr_d  = sig_addr;
          size_d  = sig_size;
          write_d = sig_write;
          beat_d  = '0;
          wait_d  = '0;
          if ((sig_read == sig_write) || range_bad) begin
            state_d = ST_ERR;
          end else begin
            state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (!sig_bip) begin
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_DATA;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_DATA: begin
        if (!sig_bip) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          beat_d = beat_q + 3'd1;
          wait_d = '0;
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  peripheral_bus_slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk  (sig_clock),
    .we   (mem_we),
    .addr (addr_q[MEM_AW-1:0]),
    .wdata(sig_data_in),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_peripheral_bus_slave.sv
// Scoreboard bench for peripheral_bus_slave: one instance with one wait state, one with none.
module tb_peripheral_bus_slave;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n    [2];
  logic [15:0] addr     [2];
  logic [1:0]  size     [2];
  logic        rd       [2];
  logic        wr       [2];
  logic        start    [2];
  logic        bip      [2];
  logic [7:0]  data_in  [2];
  logic [7:0]  data_out [2];
  logic        data_oe  [2];
  logic        bus_wait [2];
  logic        bus_err  [2];

  logic [7:0]  model [2][256];
  exp_t        sb_q0[$];
  exp_t        sb_q1[$];

  int tests;
  int failures;

  // Instance 0 inserts one wait state per beat, instance 1 runs back-to-back.
  peripheral_bus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_CYCLES(1)) u_dut_w1 (
    .sig_clock(clk), .sig_reset(rst_n[0]), .sig_addr(addr[0]), .sig_size(size[0]),
    .sig_read(rd[0]), .sig_write(wr[0]), .sig_start(start[0]), .sig_bip(bip[0]),
    .sig_data_in(data_in[0]), .sig_data_out(data_out[0]), .sig_data_oe(data_oe[0]),
    .sig_wait(bus_wait[0]), .sig_error(bus_err[0])
  );

  peripheral_bus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .sig_clock(clk), .sig_reset(rst_n[1]), .sig_addr(addr[1]), .sig_size(size[1]),
    .sig_read(rd[1]), .sig_write(wr[1]), .sig_start(start[1]), .sig_bip(bip[1]),
    .sig_data_in(data_in[1]), .sig_data_out(data_out[1]), .sig_data_oe(data_oe[1]),
    .sig_wait(bus_wait[1]), .sig_error(bus_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int d, input bit is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    if (d == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read byte or error pulse the DUT presents is matched against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1) begin
        if (data_oe[d] === 1'b1 || bus_err[d] === 1'b1) begin
          if ((d == 0 && sb_q0.size() == 0) || (d == 1 && sb_q1.size() == 0)) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_rsp dut%0d: oe=%0b err=%0b data=%0h, expected no response",
                     d, data_oe[d], bus_err[d], data_out[d]);
          end else begin
            exp_t e;
            if (d == 0) e = sb_q0.pop_front();
            else        e = sb_q1.pop_front();
            checkOutput($sformatf("rsp_is_err dut%0d", d), 32'(bus_err[d]), 32'(e.is_err));
            if (!e.is_err) checkOutput($sformatf("rd_data dut%0d", d), 32'(data_out[d]), 32'(e.data));
          end
        end else begin
          checkOutput($sformatf("data_out_zero dut%0d", d), 32'(data_out[d]), 32'd0);
        end
      end
    end
  end

  // Runs one complete transfer on DUT d starting just after a rising edge. abort_at >= 0
  // drops bip right after that beat; noisy keeps start asserted with junk while busy.
  task automatic applyStimulus(input int d, input bit r, input bit w, input logic [15:0] a,
                               input logic [1:0] sz, input logic [63:0] wdata,
                               input int abort_at, input bit exp_err, input bit noisy);
    int n;
    int ws;
    n  = 1 << sz;
    ws = (d == 0) ? 1 : 0;
    start[d] = 1'b1; bip[d] = 1'b1; addr[d] = a; size[d] = sz; rd[d] = r; wr[d] = w;
    step();
    start[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'h0000;
    if (exp_err) begin
      pushExp(d, 1'b1, 8'h00);
      @(negedge clk);
      checkOutput("err_pulse", 32'(bus_err[d]), 32'd1);
      checkOutput("err_no_wait", 32'(bus_wait[d]), 32'd0);
      step();
      bip[d] = 1'b0;
      @(negedge clk);
      checkOutput("err_one_cycle", 32'(bus_err[d]), 32'd0);
      checkOutput("err_no_data", 32'(data_oe[d]), 32'd0);
      step();
      return;
    end
    if (noisy) begin
      start[d] = 1'b1; addr[d] = 16'h0080; rd[d] = !r; wr[d] = !w;
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < ws; c++) begin
        data_in[d] = 8'hEE;
        @(negedge clk);
        checkOutput($sformatf("wait_hi beat%0d", k), 32'(bus_wait[d]), 32'd1);
        checkOutput($sformatf("oe_lo_wait beat%0d", k), 32'(data_oe[d]), 32'd0);
        step();
      end
      data_in[d] = wdata[8*k +: 8];
      if (r) pushExp(d, 1'b0, model[d][(a + k) & 255]);
      if (w) model[d][(a + k) & 255] = wdata[8*k +: 8];
      @(negedge clk);
      checkOutput($sformatf("wait_lo beat%0d", k), 32'(bus_wait[d]), 32'd0);
      checkOutput($sformatf("oe_data beat%0d", k), 32'(data_oe[d]), 32'(r));
      step();
      if (k == abort_at) begin
        start[d] = 1'b0; bip[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; data_in[d] = 8'hEE;
        @(negedge clk);
        checkOutput("abort_oe_lo", 32'(data_oe[d]), 32'd0);
        step();
        @(negedge clk);
        checkOutput("abort_idle_wait", 32'(bus_wait[d]), 32'd0);
        checkOutput("abort_no_err", 32'(bus_err[d]), 32'd0);
        checkOutput("abort_idle_oe", 32'(data_oe[d]), 32'd0);
        step();
        return;
      end
    end
    start[d] = 1'b0; bip[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
    @(negedge clk);
    checkOutput("end_idle_wait", 32'(bus_wait[d]), 32'd0);
    checkOutput("end_idle_oe", 32'(data_oe[d]), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests    = 0;
    failures = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; addr[d] = '0; size[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
      start[d] = 1'b0; bip[d] = 1'b0; data_in[d] = '0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_wait dut%0d", d), 32'(bus_wait[d]), 32'd0);
      checkOutput($sformatf("rst_oe dut%0d", d), 32'(data_oe[d]), 32'd0);
      checkOutput($sformatf("rst_dout dut%0d", d), 32'(data_out[d]), 32'd0);
      checkOutput($sformatf("rst_err dut%0d", d), 32'(bus_err[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // One wait state: 4-byte write then readback with start noise during the read.
    applyStimulus(0, 0, 1, 16'h0010, 2'd2, 64'h0000_0000_4433_2211, -1, 0, 0);
    applyStimulus(0, 1, 0, 16'h0010, 2'd2, 64'h0, -1, 0, 1);

    // Range boundary: the last two bytes are legal, four bytes from 0xFE are not.
    applyStimulus(0, 0, 1, 16'h00FE, 2'd1, 64'h0000_0000_0000_DDCC, -1, 0, 0);
    applyStimulus(0, 0, 1, 16'h00FE, 2'd2, 64'h0000_0000_1234_5678, -1, 1, 0);
    applyStimulus(0, 1, 0, 16'hFFFF, 2'd0, 64'h0, -1, 1, 0);
    applyStimulus(0, 0, 0, 16'h0000, 2'd0, 64'h0, -1, 1, 0);
    applyStimulus(0, 1, 0, 16'h00FE, 2'd1, 64'h0, -1, 0, 0);

    // Abort: prefill, then abort an 8-byte write after beat 2 and read everything back.
    applyStimulus(0, 0, 1, 16'h0020, 2'd3, 64'h5756_5554_5352_5150, -1, 0, 0);
    applyStimulus(0, 0, 1, 16'h0020, 2'd3, 64'hA7A6_A5A4_A3A2_A1A0, 2, 0, 0);
    applyStimulus(0, 1, 0, 16'h0020, 2'd3, 64'h0, -1, 0, 0);

    // Reset during the wait state of beat 1 of a read.
    start[0] = 1'b1; bip[0] = 1'b1; addr[0] = 16'h0010; size[0] = 2'd2; rd[0] = 1'b1;
    step();
    start[0] = 1'b0; rd[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wait0", 32'(bus_wait[0]), 32'd1);
    step();
    pushExp(0, 1'b0, 8'h11);
    @(negedge clk);
    checkOutput("rst_mid_oe0", 32'(data_oe[0]), 32'd1);
    step();
    #1;
    rst_n[0] = 1'b0;
    #1;
    checkOutput("rst_mid_wait", 32'(bus_wait[0]), 32'd0);
    checkOutput("rst_mid_oe", 32'(data_oe[0]), 32'd0);
    checkOutput("rst_mid_dout", 32'(data_out[0]), 32'd0);
    checkOutput("rst_mid_err", 32'(bus_err[0]), 32'd0);
    bip[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_wait", 32'(bus_wait[0]), 32'd0);
    step();
    applyStimulus(0, 1, 0, 16'h0011, 2'd0, 64'h0, -1, 0, 0);

    // No wait states: eight back-to-back beats each way, then a both-set error at 0x0004.
    applyStimulus(1, 0, 1, 16'h0000, 2'd3, 64'h0706_0504_0302_0100, -1, 0, 0);
    applyStimulus(1, 1, 0, 16'h0000, 2'd3, 64'h0, -1, 0, 1);
    applyStimulus(1, 1, 1, 16'h0004, 2'd0, 64'h0, -1, 1, 0);
    applyStimulus(1, 1, 0, 16'h0004, 2'd0, 64'h0, -1, 0, 0);
    applyStimulus(1, 0, 1, 16'h0030, 2'd2, 64'h0000_0000_DDCC_BBAA, 1, 0, 0);
    applyStimulus(1, 1, 0, 16'h0030, 2'd1, 64'h0, -1, 0, 0);

    repeat (2) step();
    checkOutput("sb_empty dut0", 32'(sb_q0.size()), 32'd0);
    checkOutput("sb_empty dut1", 32'(sb_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/peripheral_bus_slave.md
Name: peripheral_bus_slave

Overview:
Byte-wide memory-mapped slave that consumes transactions driven onto the peripheral bus (addr/size/read/write/start/bip) and answers with read data, wait states and error.
- Downstream stage of the peripheral bus interface; serves as the DUT-side responder for the UVM bench.
- Transfers of 1/2/4/8 bytes, one byte per beat, little-endian address increment.
- Programmable wait states per beat.

Parameters:
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 8, bus data width (one byte per beat)
MEM_DEPTH, 256, bytes of backing storage; legal addresses 0..MEM_DEPTH-1
WAIT_CYCLES, 1, wait cycles inserted before each beat completes (0..15)

Ports:
sig_clock  in  1  bus clock, all logic rising-edge
sig_reset  in  1  asynchronous active-low reset
sig_addr  in  16  start byte address, sampled with sig_start
sig_size  in  2  transfer length 2^size bytes (0=1, 1=2, 2=4, 3=8)
sig_read  in  1  read request, sampled with sig_start
sig_write  in  1  write request, sampled with sig_start
sig_start  in  1  one-cycle address-phase strobe
sig_bip  in  1  burst in progress; master holds high from start until last beat completes
sig_data_in  in  8  write data from master
sig_data_out  out  8  read data to master
sig_data_oe  out  1  high while slave drives read data (master uses it as bus direction)
sig_wait  out  1  high = current beat not complete
sig_error  out  1  one-cycle error response

Behaviour:
- Reset (sig_reset low, async): state IDLE; sig_data_out=0, sig_data_oe=0, sig_wait=0, sig_error=0; beat counter and address register cleared. Memory contents are not reset.
- States: IDLE, WAIT, DATA, ERR.
- IDLE, sig_start=1: latch addr, size and direction; nbytes = 1<<size; beat count = 0.
  - If read and write are both 1 or both 0, or addr+nbytes-1 >= MEM_DEPTH: go to ERR.
  - Otherwise go to WAIT if WAIT_CYCLES>0, else DATA.
- WAIT: sig_wait=1 for exactly WAIT_CYCLES cycles, then DATA.
- DATA: one cycle, sig_wait=0; the beat completes.
  - Write: mem[addr] <= sig_data_in on that edge.
  - Read: sig_data_out=mem[addr], sig_data_oe=1 during this cycle only.
  - Then addr+1 and beat+1. If beat==nbytes-1, go to IDLE; else go to WAIT (or DATA if WAIT_CYCLES=0).
- ERR: sig_error=1 for one cycle, no memory access, then IDLE.
- Latency: with start at cycle T, beat k (0-based) completes at cycle T+1+WAIT_CYCLES+k*(WAIT_CYCLES+1). For WAIT_CYCLES=0, beats are back-to-back.
- sig_data_out is 0 whenever sig_data_oe=0.
- sig_wait is 0 in IDLE and ERR.
- Abort: sig_bip sampled 0 in WAIT or DATA before the last beat completes → go to IDLE next cycle. Beats already completed stand, the current beat is discarded, no error.
- sig_start outside IDLE is ignored and has no effect on the transfer in flight.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values. A write beat whose edge coincides with reset assertion is not performed.
- Address arithmetic is ADDR_WIDTH bits. The range check prevents wrap, so no transfer crosses MEM_DEPTH.

Decomposition:
- Package peripheral_bus_pkg holds:
  - state enum (IDLE, WAIT, DATA, ERR);
  - size-to-length function (1<<size);
  - ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module peripheral_bus_slave_mem: single-port byte RAM, MEM_DEPTH x 8, synchronous write, combinational read.
- The top holds the FSM, wait counter, beat counter and address register.

Test Plan:
- WAIT_CYCLES=1: write size=2 at addr 0x0010 with data 0x11,0x22,0x33,0x44 → sig_wait pattern 1,0 per beat. Then read size=2 at 0x0010 → data_out 0x11,0x22,0x33,0x44, oe high only on DATA cycles, error never set.
- WAIT_CYCLES=0: read size=3 at 0x0000 after writing 0x00..0x07 → eight consecutive DATA cycles starting at T+1, sig_wait constantly 0.
- Start with read=1 and write=1 at 0x0004 → sig_error=1 at T+1 for one cycle, no memory change, IDLE at T+2.
- Range error: MEM_DEPTH=256, size=2 at 0x00FE → sig_error pulse, no data phase, bytes 0xFE/0xFF unchanged.
- Abort: write size=3 at 0x0020, drop sig_bip after beat 2 completes → bytes 0x20..0x22 written, 0x23 untouched, IDLE next cycle, no error.
- Reset mid-transfer: assert sig_reset low during WAIT of beat 1 of a read → outputs 0 immediately (async), IDLE after release. A new start is accepted normally afterwards.
